// File: rtl/code_display_decoder.sv
// Receives (code, none) tokens, keeps a 4-deep history, drives a one-hot LED vector and a 4-digit scanned 7-seg display.
// Latency: onehot/count/seg update one cycle after accept. Backpressure: in_ready drops for HOLD_CYC cycles after each accept and during clr.
module code_display_decoder #(
    parameter int SCAN_DIV = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_none,
    input  logic       clr,
    output logic [7:0] onehot,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [2:0] count
);

    localparam int HW = $clog2(HOLD_CYC + 2);
    localparam int DW = $clog2(SCAN_DIV + 1);

    typedef struct packed {
        logic       valid;
        logic       none;
        logic [2:0] code;
    } slot_t;

    typedef enum logic {ST_READY, ST_HOLD} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic            accept;
    slot_t           slots [4];
    logic [DW-1:0]   div;
    logic [1:0]      digit;
    slot_t           cur;

    assign accept = in_valid & in_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_READY;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_READY: if (accept && (HOLD_CYC != 0)) state_nxt = ST_HOLD;
            ST_HOLD:  if (hold_cnt == HW'(1))        state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state == ST_READY) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (accept && (HOLD_CYC != 0)) begin
            hold_cnt <= HW'(HOLD_CYC);
        end else if (state == ST_HOLD) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    // History shift register; clr wins over a same-cycle accept (in_ready is low then anyway).
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < 4; i++) slots[i] <= '0;
            count  <= 3'd0;
            onehot <= 8'h00;
        end else if (accept) begin
            slots[3] <= slots[2];
            slots[2] <= slots[1];
            slots[1] <= slots[0];
            slots[0] <= '{valid: 1'b1, none: in_none, code: in_code};
            if (count != 3'd4) count <= count + 3'd1;
            onehot <= in_none ? 8'h00 : (8'h01 << in_code);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div   <= '0;
            digit <= 2'd0;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            div   <= '0;
            digit <= digit + 2'd1;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign an  = ~(4'b0001 << digit);
    assign cur = slots[digit];

    always_comb begin
        seg = 8'hFF;
        if (cur.valid) begin
            if (cur.none) begin
                seg = 8'hFD;
            end else begin
                case (cur.code)
                    3'd0: seg = 8'h03;
                    3'd1: seg = 8'h9F;
                    3'd2: seg = 8'h25;
                    3'd3: seg = 8'h0D;
                    3'd4: seg = 8'h99;
                    3'd5: seg = 8'h49;
                    3'd6: seg = 8'h41;
                    3'd7: seg = 8'h1F;
                    default: seg = 8'hFF;
                endcase
            end
        end
    end

endmodule
